// File: rtl/soc_bus_pkg.sv
// Shared SoC peripheral bus definitions: arbiter state/owner types, bus widths
// and the address-region map used by the arbiter and the subordinate mux.
package soc_bus_pkg;

  localparam int unsigned SOC_DATA_WIDTH = 32;
  localparam int unsigned SOC_BE_WIDTH   = 4;

  localparam logic [SOC_DATA_WIDTH-1:0] DEFAULT_ERR_RDATA = 32'hDEAD_BEEF;

  // Region selectors occupy address bits [27:24].
  localparam logic [3:0] REGION_RAM       = 4'h0;
  localparam logic [3:0] REGION_SPI_FLASH = 4'h2;
  localparam logic [3:0] REGION_UART      = 4'hA;
  localparam logic [3:0] REGION_LED       = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_DATA,
    OWN_INSTR
  } arb_owner_t;

  function automatic logic [3:0] addr_region(input logic [31:0] addr);
    return addr[27:24];
  endfunction

  function automatic logic is_mapped(input logic [31:0] addr);
    logic [3:0] region;
    region = addr_region(addr);
    return (region == REGION_RAM) || (region == REGION_SPI_FLASH) ||
           (region == REGION_UART) || (region == REGION_LED);
  endfunction

endpackage

// File: rtl/soc_bus_arbiter.sv
// Arbitrates the instruction-fetch and data OBI managers onto the single peripheral bus,
// holding the winner's request fields stable until its response or a watchdog timeout.
module soc_bus_arbiter
  import soc_bus_pkg::*;
#(
  parameter int unsigned               ADDR_WIDTH      = 32,
  parameter int unsigned               MAX_DATA_STREAK = 4,
  parameter int unsigned               TIMEOUT_CYCLES  = 1024,
  parameter logic [SOC_DATA_WIDTH-1:0] ERR_RDATA       = DEFAULT_ERR_RDATA
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,

  input  logic                      instr_req_i,
  input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
  output logic                      instr_gnt_o,
  output logic                      instr_rvalid_o,
  output logic [SOC_DATA_WIDTH-1:0] instr_rdata_o,

  input  logic                      data_req_i,
  input  logic [ADDR_WIDTH-1:0]     data_addr_i,
  input  logic                      data_we_i,
  input  logic [SOC_BE_WIDTH-1:0]   data_be_i,
  input  logic [SOC_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic [SOC_DATA_WIDTH-1:0] data_rdata_o,

  output logic                      bus_req_o,
  output logic [ADDR_WIDTH-1:0]     bus_addr_o,
  output logic                      bus_we_o,
  output logic [SOC_BE_WIDTH-1:0]   bus_be_o,
  output logic [SOC_DATA_WIDTH-1:0] bus_wdata_o,
  input  logic                      bus_gnt_i,
  input  logic                      bus_rvalid_i,
  input  logic [SOC_DATA_WIDTH-1:0] bus_rdata_i,

  output logic                      timeout_o,
  output logic                      busy_o
);

  localparam logic [7:0]  STREAK_MAX = 8'(MAX_DATA_STREAK);
  localparam logic [15:0] WDOG_LAST  = 16'(TIMEOUT_CYCLES - 1);

  arb_state_t state_q, state_d;
  arb_owner_t owner_q, owner_d;

  logic [7:0]                streak_q, streak_d;
  logic [15:0]               wdog_q, wdog_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic                      we_q, we_d;
  logic [SOC_BE_WIDTH-1:0]   be_q, be_d;
  logic [SOC_DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                      instr_wins;
  logic                      grant;
  logic                      resp_valid;
  logic                      resp_timeout;
  logic [SOC_DATA_WIDTH-1:0] resp_data;

  // Data normally has priority; a full streak of data wins hands the next slot to fetch.
  assign instr_wins = instr_req_i && (!data_req_i || (streak_q == STREAK_MAX));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      streak_q <= '0;
      wdog_q   <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      be_q     <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    streak_d     = streak_q;
    wdog_d       = wdog_q;
    addr_d       = addr_q;
    we_d         = we_q;
    be_d         = be_q;
    wdata_d      = wdata_q;
    grant        = 1'b0;
    resp_valid   = 1'b0;
    resp_timeout = 1'b0;
    resp_data    = '0;

    case (state_q)
      IDLE: begin
        if (instr_wins) begin
          owner_d  = OWN_INSTR;
          addr_d   = instr_addr_i;
          we_d     = 1'b0;
          be_d     = '1;
          wdata_d  = '0;
          streak_d = '0;
          state_d  = REQ;
        end else if (data_req_i) begin
          owner_d = OWN_DATA;
          addr_d  = data_addr_i;
          we_d    = data_we_i;
          be_d    = data_be_i;
          wdata_d = data_wdata_i;
          if (instr_req_i) begin
            streak_d = (streak_q >= STREAK_MAX) ? STREAK_MAX : streak_q + 8'd1;
          end else begin
            streak_d = '0;
          end
          state_d = REQ;
        end
      end

      REQ: begin
        if (bus_gnt_i) begin
          grant   = 1'b1;
          wdog_d  = '0;
          state_d = RESP;
        end
      end

      RESP: begin
        // A real response on the expiry cycle takes precedence over the error reply.
        if (bus_rvalid_i) begin
          resp_valid = 1'b1;
          resp_data  = bus_rdata_i;
          state_d    = IDLE;
        end else if (wdog_q == WDOG_LAST) begin
          resp_valid   = 1'b1;
          resp_timeout = 1'b1;
          resp_data    = ERR_RDATA;
          state_d      = IDLE;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Every output is forced low while reset is asserted, even before the reset edge lands.
  assign bus_req_o   = rst_ni && (state_q == REQ);
  assign busy_o      = rst_ni && (state_q != IDLE);
  assign bus_addr_o  = rst_ni ? addr_q : '0;
  assign bus_we_o    = rst_ni && we_q;
  assign bus_be_o    = rst_ni ? be_q : '0;
  assign bus_wdata_o = rst_ni ? wdata_q : '0;

  assign instr_gnt_o    = rst_ni && grant && (owner_q == OWN_INSTR);
  assign data_gnt_o     = rst_ni && grant && (owner_q == OWN_DATA);
  assign instr_rvalid_o = rst_ni && resp_valid && (owner_q == OWN_INSTR);
  assign data_rvalid_o  = rst_ni && resp_valid && (owner_q == OWN_DATA);
  assign instr_rdata_o  = instr_rvalid_o ? resp_data : '0;
  assign data_rdata_o   = data_rvalid_o ? resp_data : '0;
  assign timeout_o      = rst_ni && resp_timeout;

endmodule

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
- Shares the single SoC peripheral bus (RAM, SPI flash, UART, LED) between the core's instruction-fetch and data OBI manager ports.
- Replaces the inline GNT_NONE/GNT_DATA/GNT_INSTR arbiter.
- Latches the winning request so address and controls stay stable from request until response. This lets slow subordinates such as SPI flash decode rdata safely.
- Adds starvation protection for instruction fetch and a response watchdog.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.
- MAX_DATA_STREAK, 4, consecutive data grants allowed while instr_req_i is pending before instr is forced to win; range 1..255.
- TIMEOUT_CYCLES, 1024, cycles in RESP without bus_rvalid_i before the watchdog fires; range 2..65535.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- instr_req_i  in  1  instruction request
- instr_addr_i  in  ADDR_WIDTH  instruction address
- instr_gnt_o  out  1  instruction grant
- instr_rvalid_o  out  1  instruction response valid
- instr_rdata_o  out  32  instruction read data
- data_req_i  in  1  data request
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  data write enable
- data_be_i  in  4  data byte enables
- data_wdata_i  in  32  data write data
- data_gnt_o  out  1  data grant
- data_rvalid_o  out  1  data response valid
- data_rdata_o  out  32  data read data
- bus_req_o  out  1  request to subordinate mux
- bus_addr_o  out  ADDR_WIDTH  latched address
- bus_we_o  out  1  latched write enable
- bus_be_o  out  4  latched byte enables
- bus_wdata_o  out  32  latched write data
- bus_gnt_i  in  1  subordinate grant
- bus_rvalid_i  in  1  subordinate response valid
- bus_rdata_i  in  32  subordinate read data
- timeout_o  out  1  one-cycle pulse when the watchdog fires
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (synchronous, rst_ni=0 at clk_i edge):
  - State goes to IDLE and owner to NONE.
  - Streak counter, watchdog counter and all latched bus fields clear to 0.
  - All outputs are 0 during and after reset.
  - Reset mid-transaction abandons it; no gnt or rvalid is issued for it.
- States: IDLE, REQ, RESP. At most one outstanding bus transaction.
- IDLE, arbitration:
  - If only one req_i is high, that port wins.
  - If both are high, data wins unless streak == MAX_DATA_STREAK; then instr wins.
  - The winner's addr/we/be/wdata are registered into bus_* at this edge (instr: we=0, be=4'hF, wdata=0). Owner is registered and the next state is REQ.
  - If neither req_i is high, stay in IDLE.
- Streak counter (8-bit):
  - Increments on a data win while instr_req_i=1.
  - Clears on any instr win, or on a data win with instr_req_i=0.
  - Saturates at MAX_DATA_STREAK.
- REQ:
  - bus_req_o=1; bus_* fields held constant.
  - On bus_gnt_i=1, the owner's gnt_o=1 in the same cycle (combinational). Next state is RESP and the watchdog clears.
  - The non-owner gnt_o is always 0.
  - Bus request to grant latency is therefore ≥1 cycle after manager req.
- RESP:
  - bus_req_o=0; bus_* fields still held (a subordinate may decode rdata from bus_addr_o).
  - On bus_rvalid_i=1, the owner's rvalid_o=1 and its rdata_o = bus_rdata_i, same cycle. Next state is IDLE.
  - If bus_rvalid_i and gnt arrive in the same cycle while in REQ, the rvalid is ignored (rvalid is only honoured in RESP).
- Watchdog (16-bit):
  - Counts cycles in RESP.
  - When it reaches TIMEOUT_CYCLES-1 without bus_rvalid_i: owner rvalid_o=1, rdata_o=ERR_RDATA, timeout_o=1 for that cycle, next state IDLE.
  - If rvalid arrives on the expiry cycle, real data wins and timeout_o=0.
  - Stray bus_rvalid_i in IDLE or REQ is dropped.
- Non-owner outputs: rvalid_o=0 and rdata_o=0 at all times. Owner rdata_o=0 whenever its rvalid_o=0.
- Back-to-back: after rvalid the arbiter is in IDLE next cycle. Minimum transaction is IDLE, REQ, RESP = 3 cycles for a single-cycle subordinate.
- Manager req/addr changes after gnt do not affect bus_* (fields are latched).

Decomposition:
- Package soc_bus_pkg holds:
  - typedef arb_state_t {IDLE, REQ, RESP}
  - typedef arb_owner_t {OWN_NONE, OWN_DATA, OWN_INSTR}
  - constants SOC_DATA_WIDTH=32, SOC_BE_WIDTH=4
  - default ERR_RDATA
- The region masks (RAM 4'h0, SPI flash 4'h2, UART 4'hA, LED 4'hF) move to the same package for reuse by the subordinate mux.
- No sub-module needed; a single module is natural.

Test Plan:
- Only data_req_i=1, addr 0x0000_0010, we=1, wdata 0x1234_5678; subordinate grants the same cycle and rvalid next cycle:
  - bus_addr_o=0x10 and bus_wdata_o=0x12345678 the cycle after req.
  - data_gnt_o in REQ, data_rvalid_o one cycle later.
  - instr_gnt_o stays 0 throughout.
- Both reqs held continuously with MAX_DATA_STREAK=4: grant order is D,D,D,D,I,D,D,D,D,I.
- SPI flash read at 0x0220_0000 with bus_gnt_i after 5 cycles and bus_rvalid_i after 100 cycles; instr_addr_i toggles after gnt:
  - bus_addr_o is stable at 0x0220_0000 until rvalid.
  - instr_rdata_o equals bus_rdata_i (0x0000_0013).
- TIMEOUT_CYCLES=8, subordinate never asserts rvalid:
  - In the 8th RESP cycle, data_rvalid_o=1 with rdata 0xDEADBEEF and timeout_o pulses.
  - A later stray bus_rvalid_i is ignored.
- rst_ni=0 for one cycle while in RESP: all outputs 0 next cycle, state IDLE, no rvalid for the abandoned transaction; a new request completes normally.
- bus_rvalid_i asserted in the same cycle as bus_gnt_i: no rvalid_o that cycle; the arbiter stays in RESP until the next bus_rvalid_i.
